// File: rtl/iccm_readback_pkg.sv
// Shared types and constants for the ICCM read-back engine.
//   rb_state_t : main sequencer states (IDLE/REQ/WAIT/SEND/DONE)
//   tx_state_t : UART transmitter states (IDLE/START/DATA/STOP)
//   BytesPerWord, FrameBits : word/frame geometry
package iccm_readback_pkg;

  localparam int BytesPerWord = 4;
  localparam int FrameBits    = 10;  // start + 8 data + stop

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_DONE
  } rb_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/iccm_readback_if.sv
// SRAM-side read port of the ICCM as seen by the read-back engine.
//   req_o    : one-cycle read strobe (engine -> memory)
//   addr_o   : word address, valid with req_o (engine -> memory)
//   rdata_i  : read data (memory -> engine)
//   rvalid_i : read data valid, >= 1 cycle after req_o (memory -> engine)
// master = read-back engine, slave = memory.
interface iccm_readback_if #(
  parameter int AddrW = 12
) ();
  logic             req_o;
  logic [AddrW-1:0] addr_o;
  logic [31:0]      rdata_i;
  logic             rvalid_i;

  modport master (output req_o, addr_o, input rdata_i, rvalid_i);
  modport slave  (input req_o, addr_o, output rdata_i, rvalid_i);
endinterface

// File: rtl/iccm_readback_uart_tx_core.sv
// 8N1 UART transmitter core.
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   tx_start_i       : load tx_byte_i and begin a frame (idle or last stop cycle)
//   tx_byte_i        : byte to send, LSB first
//   clks_per_bit_i   : bit period in clocks (0 behaves as 1)
//   tx_o             : serial line, idles high
//   tx_busy_o        : a frame is in progress
//   tx_done_o        : high during the last stop-bit cycle
// Accepting tx_start_i in the tx_done_o cycle gives back-to-back frames.
module uart_tx_core
  import iccm_readback_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        tx_start_i,
  input  logic [7:0]  tx_byte_i,
  input  logic [15:0] clks_per_bit_i,
  output logic        tx_o,
  output logic        tx_busy_o,
  output logic        tx_done_o
);

  localparam logic [2:0] LastBit = 3'(FrameBits - 3);

  tx_state_t   st, st_nxt;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [15:0] per_m1;
  logic        bit_last;
  logic        accept;

  assign per_m1   = (clks_per_bit_i == 16'd0) ? 16'd0 : clks_per_bit_i - 16'd1;
  assign bit_last = (cnt == per_m1);
  assign accept   = tx_start_i && ((st == TX_IDLE) || tx_done_o);

  always_ff @(posedge clock) begin
    if (reset) st <= TX_IDLE;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      TX_IDLE:  if (tx_start_i) st_nxt = TX_START;
      TX_START: if (bit_last) st_nxt = TX_DATA;
      TX_DATA:  if (bit_last && (bit_idx == LastBit)) st_nxt = TX_STOP;
      TX_STOP:  if (bit_last) st_nxt = tx_start_i ? TX_START : TX_IDLE;
      default:  st_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_o      = 1'b1;
    tx_busy_o = (st != TX_IDLE);
    tx_done_o = (st == TX_STOP) && bit_last;
    case (st)
      TX_START: tx_o = 1'b0;
      TX_DATA:  tx_o = shreg[0];
      default:  tx_o = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (accept) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= tx_byte_i;
    end else if (st != TX_IDLE) begin
      if (bit_last) begin
        cnt <= '0;
        if (st == TX_DATA) begin
          shreg   <= {1'b0, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/iccm_readback.sv
// ICCM read-back engine: on start, reads word_count_i words from the ICCM
// beginning at start_addr_i (wrapping mod 2^AddrW) and sends each word as
// four UART bytes, LSB byte first.
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   start_i            : start request, honoured only when idle
//   start_addr_i       : first word address (sampled on start)
//   word_count_i       : words to send, 0..2^AddrW (sampled on start)
//   clks_per_bit_i     : UART bit period, 0 behaves as 1 (sampled on start)
//   mem                : ICCM read port (req/addr/rdata/rvalid)
//   tx_o               : UART serial output
//   busy_o             : transfer in progress (start through done)
//   done_o             : one-cycle completion pulse
module iccm_readback
  import iccm_readback_pkg::*;
#(
  parameter int AddrW = 12,
  parameter int CntW  = 13
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [AddrW-1:0] start_addr_i,
  input  logic [CntW-1:0]  word_count_i,
  input  logic [15:0]      clks_per_bit_i,
  iccm_readback_if.master  mem,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [1:0] LastByte = 2'(BytesPerWord - 1);

  rb_state_t        st, st_nxt;
  logic [AddrW-1:0] addr_q;
  logic [CntW-1:0]  rem_q;
  logic [15:0]      cpb_q;
  logic [31:0]      word_q;
  logic [1:0]       idx_q;
  logic [1:0]       nidx;

  logic             tx_start;
  logic [7:0]       tx_byte;
  logic             tx_busy;
  logic             tx_done;
  logic             word_end;

  assign nidx     = idx_q + 2'd1;
  assign word_end = (st == S_SEND) && tx_done && (idx_q == LastByte);

  // Byte 0 goes straight from the read bus so its start bit lands on the
  // edge that captures rdata; later bytes come from the latched word and
  // are launched in the previous frame's last stop cycle.
  always_comb begin
    tx_start = 1'b0;
    tx_byte  = word_q[{nidx, 3'b000} +: 8];
    if (st == S_WAIT) begin
      tx_byte  = mem.rdata_i[7:0];
      tx_start = mem.rvalid_i && !tx_busy;
    end else if ((st == S_SEND) && tx_done && (idx_q != LastByte)) begin
      tx_start = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) st <= S_IDLE;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE:  if (start_i) st_nxt = (word_count_i == '0) ? S_DONE : S_REQ;
      S_REQ:   st_nxt = S_WAIT;
      S_WAIT:  if (mem.rvalid_i) st_nxt = S_SEND;
      S_SEND:  if (word_end) st_nxt = (rem_q == CntW'(1)) ? S_DONE : S_REQ;
      S_DONE:  st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem.req_o  = (st == S_REQ);
    mem.addr_o = addr_q;
    busy_o     = (st != S_IDLE);
    done_o     = (st == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      rem_q  <= '0;
      cpb_q  <= 16'd1;
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      if ((st == S_IDLE) && start_i) begin
        addr_q <= start_addr_i;
        rem_q  <= word_count_i;
        cpb_q  <= (clks_per_bit_i == 16'd0) ? 16'd1 : clks_per_bit_i;
      end
      if ((st == S_WAIT) && mem.rvalid_i) begin
        word_q <= mem.rdata_i;
        idx_q  <= '0;
      end
      if ((st == S_SEND) && tx_done) begin
        if (idx_q == LastByte) begin
          rem_q  <= rem_q - CntW'(1);
          addr_q <= addr_q + AddrW'(1);
        end else begin
          idx_q <= nidx;
        end
      end
    end
  end

  uart_tx_core u_tx (
    .clock          (clock),
    .reset          (reset),
    .tx_start_i     (tx_start),
    .tx_byte_i      (tx_byte),
    .clks_per_bit_i (cpb_q),
    .tx_o           (tx_o),
    .tx_busy_o      (tx_busy),
    .tx_done_o      (tx_done)
  );

endmodule

// File: tb/tb_iccm_readback.sv
module tb_iccm_readback;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [11:0] start_addr = '0;
  logic [12:0] word_count = '0;
  logic [15:0] cpb = 16'd1;
  logic        tx, busy, done;

  iccm_readback_if #(.AddrW(12)) mif ();

  iccm_readback #(.AddrW(12), .CntW(13)) dut (
    .clock          (clock),
    .reset          (reset),
    .start_i        (start_i),
    .start_addr_i   (start_addr),
    .word_count_i   (word_count),
    .clks_per_bit_i (cpb),
    .mem            (mif),
    .tx_o           (tx),
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // memory model: rvalid lat cycles after req
  logic [31:0] mem [4096];
  int          lat = 1;
  int          dly = 0;
  logic [11:0] paddr = '0;

  always @(posedge clock) begin
    if (reset) dly <= 0;
    else if (mif.req_o) begin
      dly   <= lat;
      paddr <= mif.addr_o;
    end else if (dly != 0) dly <= dly - 1;
  end
  assign mif.rdata_i  = mem[paddr];
  assign mif.rvalid_i = (dly == 1);

  // cycle counter and monitors
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          nb = 1;
  logic [7:0]  byte_q [$];
  int          t0_q [$];
  logic [11:0] req_q [$];
  int          req_cyc_q [$];
  int          done_cnt = 0, done_cyc = 0, rv_cyc = 0, tx_low = 0, frm_err = 0;
  bit          in_fr = 0;
  int          t0 = 0, off = 0, slot = 0;
  logic [7:0]  sh = '0;

  always @(negedge clock) begin
    if (reset) in_fr = 0;
    else begin
      if (mif.req_o) begin
        req_q.push_back(mif.addr_o);
        req_cyc_q.push_back(cyc);
      end
      if (mif.rvalid_i) rv_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!tx) tx_low++;
      if (!in_fr) begin
        if (!tx) begin
          in_fr = 1;
          t0    = cyc;
        end
      end else begin
        off  = cyc - t0;
        slot = off / nb;
        if (off % nb == nb / 2) begin
          if (slot >= 1 && slot <= 8) sh[slot-1] = tx;
          else if (slot == 9) begin
            if (!tx) frm_err++;
            byte_q.push_back(sh);
            t0_q.push_back(t0);
            in_fr = 0;
          end
        end
      end
    end
  end

  task automatic pulse_start(input logic [11:0] a, input logic [12:0] c, input logic [15:0] n);
    @(negedge clock);
    start_addr = a;
    word_count = c;
    cpb        = n;
    start_i    = 1'b1;
    @(negedge clock);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d;
    d  = done_cnt;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      if (done_cnt > d) ok = 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, rb, d0, fe0, tl0, e, tgt;
    bit ok;
    logic [7:0] exp_wr [12];
    logic [7:0] exp_sb [8];
    exp_wr = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
               8'hCC, 8'hBB, 8'hAA, 8'h99};
    exp_sb = '{8'h0D, 8'hF0, 8'hAD, 8'h0B, 8'hBE, 8'hBA, 8'hFE, 8'hCA};

    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h010] = 32'hA5C3_0F01;
    mem[12'hFFE] = 32'h1122_3344;
    mem[12'hFFF] = 32'h5566_7788;
    mem[12'h000] = 32'h99AA_BBCC;
    mem[12'h020] = 32'hDEAD_BEEF;
    mem[12'h030] = 32'h0BAD_F00D;
    mem[12'h031] = 32'hCAFE_BABE;
    mem[12'h040] = 32'h1234_5678;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_tx", tx, 1);
    chk("rst_req", mif.req_o, 0);
    chk("rst_addr", mif.addr_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // single word, N=4
    b = byte_q.size(); rb = req_q.size(); d0 = done_cnt; fe0 = frm_err;
    nb = 4;
    pulse_start(12'h010, 13'd1, 16'd4);
    e = cyc;
    chk("sw_busy", busy, 1);
    chk("sw_req", mif.req_o, 1);
    wait_done(500, ok);
    chk("sw_done_seen", ok, 1);
    repeat (5) @(negedge clock);
    chk("sw_nbytes", byte_q.size() - b, 4);
    chk("sw_b0", byte_q[b], 8'h01);
    chk("sw_b1", byte_q[b+1], 8'h0F);
    chk("sw_b2", byte_q[b+2], 8'hC3);
    chk("sw_b3", byte_q[b+3], 8'hA5);
    chk("sw_nreq", req_q.size() - rb, 1);
    chk("sw_addr", req_q[rb], 12'h010);
    chk("sw_req_cyc", req_cyc_q[rb], e);
    chk("sw_first_bit", t0_q[b], e + 2);
    chk("sw_contig", t0_q[b+3] - t0_q[b], 120);
    chk("sw_done_cyc", done_cyc, t0_q[b+3] + 40);
    chk("sw_ndone", done_cnt - d0, 1);
    chk("sw_frm", frm_err - fe0, 0);
    chk("sw_idle", busy, 0);

    // count 0
    rb = req_q.size(); d0 = done_cnt; tl0 = tx_low;
    pulse_start(12'h123, 13'd0, 16'd3);
    chk("c0_done", done, 1);
    chk("c0_busy", busy, 1);
    chk("c0_req", mif.req_o, 0);
    @(negedge clock);
    chk("c0_done_fall", done, 0);
    chk("c0_busy_fall", busy, 0);
    repeat (10) @(negedge clock);
    chk("c0_nreq", req_q.size() - rb, 0);
    chk("c0_txlow", tx_low - tl0, 0);
    chk("c0_ndone", done_cnt - d0, 1);

    // wrap-around, N=2
    b = byte_q.size(); rb = req_q.size(); fe0 = frm_err;
    nb = 2;
    pulse_start(12'hFFE, 13'd3, 16'd2);
    wait_done(1000, ok);
    chk("wr_done_seen", ok, 1);
    repeat (5) @(negedge clock);
    chk("wr_nreq", req_q.size() - rb, 3);
    chk("wr_a0", req_q[rb], 12'hFFE);
    chk("wr_a1", req_q[rb+1], 12'hFFF);
    chk("wr_a2", req_q[rb+2], 12'h000);
    chk("wr_nbytes", byte_q.size() - b, 12);
    for (int i = 0; i < 12; i++) chk($sformatf("wr_b%0d", i), byte_q[b+i], exp_wr[i]);
    chk("wr_gap", t0_q[b+4] - t0_q[b+3], 22);
    chk("wr_frm", frm_err - fe0, 0);

    // variable latency 5, clks_per_bit 0 -> N=1
    b = byte_q.size(); rb = req_q.size();
    nb = 1; lat = 5;
    pulse_start(12'h020, 13'd1, 16'd0);
    wait_done(500, ok);
    chk("vl_done_seen", ok, 1);
    repeat (5) @(negedge clock);
    chk("vl_rv_lat", rv_cyc - req_cyc_q[rb], 5);
    chk("vl_first_bit", t0_q[b], rv_cyc + 1);
    chk("vl_b0", byte_q[b], 8'hEF);
    chk("vl_b1", byte_q[b+1], 8'hBE);
    chk("vl_b2", byte_q[b+2], 8'hAD);
    chk("vl_b3", byte_q[b+3], 8'hDE);
    chk("vl_contig", t0_q[b+3] - t0_q[b], 30);
    lat = 1;

    // start while busy, N=2
    b = byte_q.size(); rb = req_q.size(); d0 = done_cnt;
    nb = 2;
    pulse_start(12'h030, 13'd2, 16'd2);
    repeat (30) @(negedge clock);
    chk("sb_busy_mid", busy, 1);
    pulse_start(12'h100, 13'd5, 16'd7);
    wait_done(1000, ok);
    chk("sb_done_seen", ok, 1);
    repeat (20) @(negedge clock);
    chk("sb_nreq", req_q.size() - rb, 2);
    chk("sb_a0", req_q[rb], 12'h030);
    chk("sb_a1", req_q[rb+1], 12'h031);
    chk("sb_nbytes", byte_q.size() - b, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("sb_b%0d", i), byte_q[b+i], exp_sb[i]);
    chk("sb_ndone", done_cnt - d0, 1);

    // reset during data bit 3 of byte 1, N=4
    b = byte_q.size();
    nb = 4;
    pulse_start(12'h040, 13'd1, 16'd4);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      if (byte_q.size() > b) ok = 1;
    end
    chk("rm_byte0_seen", ok, 1);
    chk("rm_b0", byte_q[b], 8'h78);
    tgt = t0_q[b] + 14 * 4 + 1;
    for (int i = 0; i < 200 && cyc < tgt; i++) @(negedge clock);
    chk("rm_busy_pre", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("rm_tx", tx, 1);
    chk("rm_busy", busy, 0);
    chk("rm_req", mif.req_o, 0);
    reset = 1'b0;
    @(negedge clock);
    b = byte_q.size(); rb = req_q.size(); d0 = done_cnt;
    nb = 1;
    pulse_start(12'h010, 13'd1, 16'd1);
    wait_done(500, ok);
    chk("rm_done_seen", ok, 1);
    repeat (5) @(negedge clock);
    chk("rm_nreq", req_q.size() - rb, 1);
    chk("rm_addr", req_q[rb], 12'h010);
    chk("rm_nbytes", byte_q.size() - b, 4);
    chk("rm_n0", byte_q[b], 8'h01);
    chk("rm_n3", byte_q[b+3], 8'hA5);
    chk("rm_ndone", done_cnt - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
